// File: rtl/mm_to_st_adapter_pkg.sv
// Shared constants for the MM-to-ST transmit adapter: register map,
// flag bit positions, and the status word layout used by readback.
package stream_adapter_pkg;

    // MM register map
    localparam logic ADDR_DATA  = 1'b0;
    localparam logic ADDR_FLAGS = 1'b1;

    // Bit positions inside a flag register write (and inside the FIFO
    // payload, above the data word)
    localparam int FLAG_SOP = 0;
    localparam int FLAG_EOP = 1;

    // Status word bit positions returned by a flag-address read
    localparam int STAT_PEND_SOP = 0;
    localparam int STAT_PEND_EOP = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_FULL     = 3;
    localparam int STAT_BITS     = 4;

    // Assemble the status word from its individual flags
    function automatic logic [STAT_BITS-1:0] pack_status(
        input logic full,
        input logic empty,
        input logic pend_eop,
        input logic pend_sop
    );
        logic [STAT_BITS-1:0] stat_v;
        stat_v                = {STAT_BITS{1'b0}};
        stat_v[STAT_FULL]     = full;
        stat_v[STAT_EMPTY]    = empty;
        stat_v[STAT_PEND_EOP] = pend_eop;
        stat_v[STAT_PEND_SOP] = pend_sop;
        return stat_v;
    endfunction

endpackage

// File: rtl/mm_to_st_adapter_if.sv
// Bus bundle for the adapter: the Avalon-MM slave side (in_*) and the
// Avalon-ST source side (out_*). The adapter uses the slave modport; a
// host/sink model uses the master modport.
interface mm_to_st_adapter_if #(
    parameter int WIDTH = 8
);
    logic             in_write;
    logic             in_read;
    logic             in_address;
    logic [WIDTH-1:0] in_writedata;
    logic             in_waitrequest;
    logic [WIDTH-1:0] in_readdata;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sop;
    logic             out_eop;

    modport slave (
        input  in_write, in_read, in_address, in_writedata, out_ready,
        output in_waitrequest, in_readdata, out_valid, out_data, out_sop, out_eop
    );

    modport master (
        output in_write, in_read, in_address, in_writedata, out_ready,
        input  in_waitrequest, in_readdata, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/mm_to_st_adapter_fifo.sv
// mm_st_fifo: small synchronous FIFO with a combinational head-of-queue
// read. Pushes into a full FIFO and pops from an empty FIFO are ignored.
module mm_st_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/mm_to_st_adapter.sv
// mm_to_st_adapter: turns Avalon-MM writes into an Avalon-ST packet stream.
// A flag write arms SOP/EOP for the next data word; a data write pushes
// {eop, sop, data} into a FIFO that drains under ready/valid.
// Optional feature macro: MM_TO_ST_READBACK_EN (zero-wait status readback).
module mm_to_st_adapter
    import stream_adapter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic               clock,
    input logic               reset,
    mm_to_st_adapter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = WIDTH + 2;

    logic             pend_sop_r;
    logic             pend_eop_r;
    logic             data_wr_s;
    logic             flag_wr_s;
    logic             push_s;
    logic             pop_s;
    logic [PW-1:0]    fifo_wdata_s;
    logic [PW-1:0]    fifo_rdata_s;
    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic [WIDTH-1:0] readdata_s;

    // MM decode; the stall looks only at the registered count, so a pop in
    // the same cycle does not let a write into a full FIFO through
    assign data_wr_s          = bus.in_write && (bus.in_address == ADDR_DATA);
    assign flag_wr_s          = bus.in_write && (bus.in_address == ADDR_FLAGS);
    assign push_s             = data_wr_s && !full_s;
    assign bus.in_waitrequest = data_wr_s && full_s;
    assign fifo_wdata_s       = {pend_eop_r, pend_sop_r, bus.in_writedata};

    // ST source straight from the FIFO head; valid depends only on state
    assign bus.out_valid = !empty_s;
    assign bus.out_data  = fifo_rdata_s[WIDTH-1:0];
    assign bus.out_sop   = fifo_rdata_s[WIDTH + FLAG_SOP];
    assign bus.out_eop   = fifo_rdata_s[WIDTH + FLAG_EOP];
    assign pop_s         = !empty_s && bus.out_ready;
    assign bus.in_readdata = readdata_s;

    // Pending packet flags: armed by a flag write, consumed by the next push
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_sop_r <= 1'b0;
            pend_eop_r <= 1'b0;
        end else if (flag_wr_s) begin
            pend_sop_r <= bus.in_writedata[FLAG_SOP];
            pend_eop_r <= bus.in_writedata[FLAG_EOP];
        end else if (push_s) begin
            pend_sop_r <= 1'b0;
            pend_eop_r <= 1'b0;
        end else begin
            pend_sop_r <= pend_sop_r;
            pend_eop_r <= pend_eop_r;
        end
    end

    mm_st_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

`ifdef MM_TO_ST_READBACK_EN
    // Zero-wait readback: occupancy at the data address, status at the flag address
    always_comb begin
        readdata_s = {WIDTH{1'b0}};
        if (bus.in_read) begin
            if (bus.in_address == ADDR_DATA) begin
                readdata_s = WIDTH'(count_s);
            end else begin
                readdata_s = WIDTH'(pack_status(full_s, empty_s, pend_eop_r, pend_sop_r));
            end
        end else begin
            readdata_s = {WIDTH{1'b0}};
        end
    end
`else
    logic [CW:0] unused_s;

    assign readdata_s = {WIDTH{1'b0}};
    assign unused_s   = {bus.in_read, count_s};
`endif
endmodule

// File: tb/tb_mm_to_st_adapter.sv
// Self-checking bench for mm_to_st_adapter. A queue-based reference model
// tracks accepted words and pending flags; outputs are compared every cycle
// half a period after the active edge.
module tb_mm_to_st_adapter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;

    mm_to_st_adapter_if #(.WIDTH(WIDTH)) bus ();

    mm_to_st_adapter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checks    = 0;
    int         failures  = 0;
    logic [9:0] mq[$];
    logic       psop      = 1'b0;
    logic       peop      = 1'b0;
    logic       last_push = 1'b0;
    logic       toggle_en  = 1'b0;
    logic       toggle_bit = 1'b0;
    int         obs_pops  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic wr, input logic addr, input logic [7:0] wd,
                        input logic rdy_in, input logic rd, input logic rst);
        logic       rdy;
        logic       full_m;
        logic       empty_m;
        logic [31:0] exp_rd;
        logic [9:0] head;
        rdy = toggle_en ? toggle_bit : rdy_in;
        toggle_bit = ~toggle_bit;
        bus.in_write     = wr;
        bus.in_address   = addr;
        bus.in_writedata = wd;
        bus.in_read      = rd;
        bus.out_ready    = rdy;
        reset            = rst;
        #1;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        check("waitrequest", 32'(bus.in_waitrequest), 32'(wr && !addr && full_m));
        check("out_valid", 32'(bus.out_valid), 32'(!empty_m));
        if (!empty_m) begin
            head = mq[0];
            check("out_data", 32'(bus.out_data), 32'(head[7:0]));
            check("out_sop", 32'(bus.out_sop), 32'(head[8]));
            check("out_eop", 32'(bus.out_eop), 32'(head[9]));
        end
`ifdef MM_TO_ST_READBACK_EN
        if (rd) begin
            if (!addr) exp_rd = 32'(mq.size());
            else exp_rd = (full_m ? 32'd8 : 32'd0) + (empty_m ? 32'd4 : 32'd0)
                        + (peop ? 32'd2 : 32'd0) + (psop ? 32'd1 : 32'd0);
        end else begin
            exp_rd = 32'd0;
        end
`else
        exp_rd = 32'd0;
`endif
        check("readdata", 32'(bus.in_readdata), exp_rd);
        if (bus.out_valid && rdy && !rst) obs_pops++;
        last_push = 1'b0;
        if (rst) begin
            mq.delete();
            psop = 1'b0;
            peop = 1'b0;
        end else begin
            if (!empty_m && rdy) void'(mq.pop_front());
            if (wr && !addr && !full_m) begin
                mq.push_back({peop, psop, wd});
                psop = 1'b0;
                peop = 1'b0;
                last_push = 1'b1;
            end else if (wr && addr) begin
                psop = wd[0];
                peop = wd[1];
            end
        end
        @(negedge clock);
    endtask

    task automatic write_flags(input logic [7:0] f, input logic rdy);
        step(1'b1, 1'b1, f, rdy, 1'b0, 1'b0);
    endtask

    // Hold a data write until accepted, bounded
    task automatic write_data(input logic [7:0] d, input logic rdy);
        int n;
        n = 0;
        last_push = 1'b0;
        while (!last_push && n < 40) begin
            step(1'b1, 1'b0, d, rdy, 1'b0, 1'b0);
            n++;
        end
        check("write_accept", 32'(last_push), 32'd1);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] t2_data [3] = '{8'h11, 8'h22, 8'h33};
    logic       t2_sop  [3] = '{1'b1, 1'b0, 1'b0};
    logic       t2_eop  [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int pops_before;
        logic [31:0] r;
        bus.in_write = 1'b0; bus.in_read = 1'b0; bus.in_address = 1'b0;
        bus.in_writedata = 8'h00; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wait", 32'(bus.in_waitrequest), 32'd0);
        check("rst_readdata", 32'(bus.in_readdata), 32'd0);
        @(negedge clock);

        // Single framed word, zero-bubble latency
        write_flags(8'h01, 1'b1);
        write_data(8'hA5, 1'b1);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data", 32'(bus.out_data), 32'hA5);
        check("t1_sop", 32'(bus.out_sop), 32'd1);
        check("t1_eop", 32'(bus.out_eop), 32'd0);
        idle(1, 1'b1);
        check("t1_drained", 32'(bus.out_valid), 32'd0);

        // Three-word packet, order and framing preserved
        write_flags(8'h01, 1'b0);
        write_data(8'h11, 1'b0);
        write_data(8'h22, 1'b0);
        write_flags(8'h02, 1'b0);
        write_data(8'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t2_data", 32'(bus.out_data), 32'(t2_data[i]));
            check("t2_sop", 32'(bus.out_sop), 32'(t2_sop[i]));
            check("t2_eop", 32'(bus.out_eop), 32'(t2_eop[i]));
            idle(1, 1'b1);
        end
        check("t2_drained", 32'(bus.out_valid), 32'd0);

        // Full stall: pop in the same cycle does not release the stall
        for (int i = 0; i < 4; i++) write_data(8'(8'h61 + i), 1'b0);
        step(1'b1, 1'b0, 8'h65, 1'b0, 1'b0, 1'b0);
        check("t3_stall", 32'(last_push), 32'd0);
        step(1'b1, 1'b0, 8'h65, 1'b1, 1'b0, 1'b0);
        check("t3_stall_on_pop", 32'(last_push), 32'd0);
        check("t3_head_after_pop", 32'(bus.out_data), 32'h62);
        step(1'b1, 1'b0, 8'h65, 1'b0, 1'b0, 1'b0);
        check("t3_accept", 32'(last_push), 32'd1);
        idle(6, 1'b1);

        // Full FIFO, toggling ready, 16 writes with wrap-around
        for (int i = 0; i < 4; i++) write_data(8'(8'h30 + i), 1'b0);
        pops_before = obs_pops;
        toggle_en = 1'b1;
        for (int i = 0; i < 16; i++) write_data(8'(8'h80 + i), 1'b0);
        toggle_en = 1'b0;
        idle(8, 1'b1);
        check("t4_pop_count", 32'(obs_pops - pops_before), 32'd20);
        check("t4_drained", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation discards contents, pending flags and a write
        for (int i = 0; i < 3; i++) write_data(8'(8'hC0 + i), 1'b0);
        write_flags(8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        check("t5_valid_after_rst", 32'(bus.out_valid), 32'd0);
        write_data(8'h5A, 1'b0);
        check("t5_valid", 32'(bus.out_valid), 32'd1);
        check("t5_data", 32'(bus.out_data), 32'h5A);
        check("t5_sop_cleared", 32'(bus.out_sop), 32'd0);
        idle(2, 1'b1);

        // Readback (expects zero when the feature is compiled out)
        write_data(8'h01, 1'b0);
        write_data(8'h02, 1'b0);
        bus.in_write = 1'b0; bus.in_read = 1'b1; bus.in_address = 1'b0; bus.out_ready = 1'b0;
        #1;
`ifdef MM_TO_ST_READBACK_EN
        check("rb_count", 32'(bus.in_readdata), 32'd2);
`else
        check("rb_disabled", 32'(bus.in_readdata), 32'd0);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        write_flags(8'h03, 1'b0);
        bus.in_write = 1'b0; bus.in_read = 1'b1; bus.in_address = 1'b1;
        #1;
`ifdef MM_TO_ST_READBACK_EN
        check("rb_status", 32'(bus.in_readdata), 32'h3);
`else
        check("rb_disabled_flags", 32'(bus.in_readdata), 32'd0);
`endif
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            step(r[0] | r[1], r[4:2] == 3'd0, r[15:8], r[16] | r[17], r[18],
                 r[31:24] == 8'd0);
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mm_to_st_adapter.md
# mm_to_st_adapter

Converts Avalon-MM slave writes into an Avalon-ST source stream with start-of-packet and end-of-packet markers. It is the transmit-side counterpart to the ST-to-MM capture path in the hamming design. Host software writes packet flags and data words. The block buffers them in a small FIFO and drains them to the downstream streaming sink under ready/valid handshake.

## Interface
- WIDTH, 8, data word width; must satisfy WIDTH >= $clog2(DEPTH)+1
- DEPTH, 4, FIFO depth in entries; power of two, >= 2
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- in_write  in  1  MM write strobe
- in_read  in  1  MM read strobe (used only with readback; see Configuration)
- in_address  in  1  0 = data register, 1 = flag register
- in_writedata  in  WIDTH  MM write data
- in_waitrequest  out  1  MM stall
- in_readdata  out  WIDTH  MM read data
- out_ready  in  1  ST sink ready
- out_valid  out  1  ST data valid
- out_data  out  WIDTH  ST data
- out_sop  out  1  ST start of packet
- out_eop  out  1  ST end of packet

## Operation
- Flag register: a write to address 1 latches in_writedata[0] into pend_sop and in_writedata[1] into pend_eop. Other bits are ignored. Flag writes never stall.
- Data write: a write to address 0 with FIFO not full pushes {pend_eop, pend_sop, in_writedata} into the FIFO. The same edge clears pend_sop and pend_eop to 0, so flags apply to exactly one word.
- Data write with FIFO full: in_waitrequest=1 and nothing changes. The master holds the write until the FIFO has room.
- in_waitrequest = in_write && in_address==0 && full. It is combinational from the registered count.
- Full is evaluated on the registered count only. A pop in the same cycle does not release the stall; the push lands on the next cycle.
- ST source: out_valid = (count != 0). out_data, out_sop and out_eop come from the FIFO head. A pop occurs when out_valid && out_ready.
- Simultaneous push and pop: count unchanged, read and write pointers both advance.
- Pointers: log2(DEPTH) bits, wrapping naturally. Count: log2(DEPTH)+1 bits, range 0..DEPTH.
- The block does not check packet framing. Whatever flags were written are forwarded unchanged.

## Timing
- Reset values: count=0, pointers=0, pend_sop=0, pend_eop=0, out_valid=0, in_waitrequest=0, in_readdata=0. out_data, out_sop and out_eop are don't-care while out_valid=0.
- Latency: a data write accepted at edge N gives out_valid=1 in the cycle after edge N, with zero bubble.
- Throughput: one word per cycle when out_ready is held high and writes are back-to-back.
- ST rule: once out_valid=1, out_data/sop/eop stay stable until a pop. out_valid never depends combinationally on out_ready.
- Reset mid-operation: FIFO contents are discarded and pending flags cleared on the reset edge. A write asserted during reset is dropped.

## Configuration
- MM_TO_ST_READBACK_EN defined: a read is zero-wait (in_waitrequest=0 for reads), with combinational in_readdata.
  - Address 0 returns the zero-extended count.
  - Address 1 returns {full, empty, pend_eop, pend_sop} in bits [3:0], upper bits 0.
- Undefined: in_readdata is tied to '0 and in_read is ignored. Port list is unchanged.

## Structure
- Package stream_adapter_pkg contains:
  - address constants ADDR_DATA=1'b0 and ADDR_FLAGS=1'b1
  - flag bit indices FLAG_SOP=0 and FLAG_EOP=1
  - status bit indices for readback
- Sub-module mm_st_fifo: a synchronous FIFO with WIDTH+2 payload, DEPTH parameter, push/pop, full/empty/count, and head-of-queue combinational read. The top level holds the flag register, MM decode and waitrequest logic.

## Test plan
- Reset, then write flags=2'b01, then write 0xA5 with out_ready=1. Expect out_valid=1 with out_data=0xA5, out_sop=1, out_eop=0 the next cycle. Then out_valid=0.
- Write 3 words 0x11, 0x22, 0x33, with flags 2'b01 before the first and 2'b10 before the last. Expect sop only on 0x11, eop only on 0x33, and the order preserved.
- With out_ready=0, write 5 words at DEPTH=4. Expect the 5th write to see in_waitrequest=1. Raise out_ready for one cycle: 0x first word pops, then the 5th write completes the following cycle.
- With full FIFO and out_ready toggling every cycle, write 16 words. Expect all 16 to arrive in order with no loss or duplication, and wrap-around exercised.
- Fill 3 entries and set pend_sop, then assert reset for one cycle. Expect out_valid=0 and count=0. The next data write is emitted with sop=0.
- With MM_TO_ST_READBACK_EN, after 2 pushes, read address 0 and expect 2. Write flags 2'b11, then read address 1 and expect 4'b0011.
